// File: rtl/frame_sequencer_2d_if.sv
// rtl/frame_sequencer_2d_if.sv - memory request port between the sequencer and the lane memory
interface frame_sequencer_2d_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_valid;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_last;
    logic                  mem_ready;

    modport master (output mem_valid, output mem_addr, output mem_last, input mem_ready);
    modport slave  (input mem_valid, input mem_addr, input mem_last, output mem_ready);
endinterface

// File: rtl/frame_sequencer_2d.sv
// rtl/frame_sequencer_2d.sv - 2-D row/column address sequencer for ternary frames
module frame_sequencer_2d #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DIM_WIDTH    = 16,
    parameter int STRIDE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     i_base_addr,
    input  logic [DIM_WIDTH-1:0]      i_frame_rows,
    input  logic [DIM_WIDTH-1:0]      i_frame_cols,
    input  logic [STRIDE_WIDTH-1:0]   i_col_stride,
    input  logic [ADDR_WIDTH-1:0]     i_row_stride,
    input  logic [31:0]               i_exec_hints,
    input  logic                      i_start,
    input  logic                      i_abort,
    frame_sequencer_2d_if.master      mem,
    output logic                      o_engine_enable,
    output logic                      o_busy,
    output logic                      o_frame_done,
    output logic                      o_frame_aborted,
    output logic [2*DIM_WIDTH-1:0]    o_elem_count
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  r_state;
    logic [DIM_WIDTH-1:0]    r_rows, r_cols, r_row_idx, r_col_idx;
    logic [ADDR_WIDTH-1:0]   r_col_eff, r_row_stride, r_row_base, r_mem_addr;
    logic                    r_mem_valid, r_mem_last, r_engine_enable, r_busy;
    logic                    r_frame_done, r_frame_aborted;
    logic [2*DIM_WIDTH-1:0]  r_elem_count;

    logic [1:0]                w_s_m1;
    logic [4:0]                w_s, w_k;
    logic [STRIDE_WIDTH+3:0]   w_col_eff;
    logic                      w_fire, w_row_end, w_next_last, w_unused_hints;
    logic [DIM_WIDTH-1:0]      w_next_row, w_next_col;
    logic [ADDR_WIDTH-1:0]     w_next_row_base;

    // Convolution ops scale the element stride by the conv stride (op 0x04) or its square (op 0x07).
    assign w_s_m1 = i_exec_hints[21:20];
    assign w_s    = {3'b000, w_s_m1} + 5'd1;
    always_comb begin
        w_k = 5'd1;
        if (i_exec_hints[7:0] == 8'h04)
            w_k = w_s;
        else if (i_exec_hints[7:0] == 8'h07)
            w_k = w_s * w_s;
    end
    assign w_col_eff      = {4'b0000, i_col_stride} * {{(STRIDE_WIDTH-1){1'b0}}, w_k};
    assign w_unused_hints = ^{i_exec_hints[31:22], i_exec_hints[19:8]};

    assign w_fire          = r_mem_valid & mem.mem_ready;
    assign w_row_end       = (r_col_idx == r_cols - DIM_WIDTH'(1));
    assign w_next_col      = w_row_end ? '0 : r_col_idx + DIM_WIDTH'(1);
    assign w_next_row      = w_row_end ? r_row_idx + DIM_WIDTH'(1) : r_row_idx;
    assign w_next_last     = (w_next_row == r_rows - DIM_WIDTH'(1)) &&
                             (w_next_col == r_cols - DIM_WIDTH'(1));
    assign w_next_row_base = r_row_base + r_row_stride;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_rows          <= '0;
            r_cols          <= '0;
            r_row_idx       <= '0;
            r_col_idx       <= '0;
            r_col_eff       <= '0;
            r_row_stride    <= '0;
            r_row_base      <= '0;
            r_mem_addr      <= '0;
            r_mem_valid     <= 1'b0;
            r_mem_last      <= 1'b0;
            r_engine_enable <= 1'b0;
            r_busy          <= 1'b0;
            r_frame_done    <= 1'b0;
            r_frame_aborted <= 1'b0;
            r_elem_count    <= '0;
        end else begin
            r_frame_done    <= 1'b0;
            r_frame_aborted <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_rows       <= i_frame_rows;
                        r_cols       <= i_frame_cols;
                        r_col_eff    <= {{(ADDR_WIDTH-STRIDE_WIDTH-4){1'b0}}, w_col_eff};
                        r_row_stride <= i_row_stride;
                        r_row_base   <= i_base_addr;
                        r_mem_addr   <= i_base_addr;
                        r_row_idx    <= '0;
                        r_col_idx    <= '0;
                        r_elem_count <= '0;
                        r_busy       <= 1'b1;
                        // An empty frame completes through DONE without issuing any request.
                        if (i_frame_rows == '0 || i_frame_cols == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state         <= S_RUN;
                            r_mem_valid     <= 1'b1;
                            r_engine_enable <= 1'b1;
                            r_mem_last      <= (i_frame_rows == DIM_WIDTH'(1)) &&
                                               (i_frame_cols == DIM_WIDTH'(1));
                        end
                    end
                end
                S_RUN: begin
                    if (i_abort) begin
                        r_state         <= S_IDLE;
                        r_mem_valid     <= 1'b0;
                        r_mem_last      <= 1'b0;
                        r_engine_enable <= 1'b0;
                        r_busy          <= 1'b0;
                        r_frame_aborted <= 1'b1;
                    end else if (w_fire) begin
                        r_elem_count <= r_elem_count + (2*DIM_WIDTH)'(1);
                        if (r_mem_last) begin
                            r_state         <= S_DONE;
                            r_mem_valid     <= 1'b0;
                            r_mem_last      <= 1'b0;
                            r_engine_enable <= 1'b0;
                        end else begin
                            r_row_idx  <= w_next_row;
                            r_col_idx  <= w_next_col;
                            r_mem_last <= w_next_last;
                            if (w_row_end) begin
                                r_row_base <= w_next_row_base;
                                r_mem_addr <= w_next_row_base;
                            end else begin
                                r_mem_addr <= r_mem_addr + r_col_eff;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                    r_frame_done <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem.mem_valid   = r_mem_valid;
    assign mem.mem_addr    = r_mem_addr;
    assign mem.mem_last    = r_mem_last;
    assign o_engine_enable = r_engine_enable;
    assign o_busy          = r_busy;
    assign o_frame_done    = r_frame_done;
    assign o_frame_aborted = r_frame_aborted;
    assign o_elem_count    = r_elem_count;
endmodule
